// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential execute unit: ALU opcodes (incl. RV-M) and FSM states.
package alu_seq_pkg;

    localparam int XLEN_DEFAULT       = 32;
    localparam int MUL_UNROLL_DEFAULT = 1;

    typedef enum logic [4:0] {
        ALU_add = 5'd0, ALU_sub, ALU_and, ALU_or, ALU_xor,
        ALU_sll, ALU_srl, ALU_sra,
        ALU_slt, ALU_sltu, ALU_ce, ALU_cne, ALU_cge, ALU_cgeu,
        ALU_mul, ALU_mulh, ALU_mulhsu, ALU_mulhu,
        ALU_div, ALU_divu, ALU_rem, ALU_remu
    } ALU_control_t;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} alu_seq_state_t;

    function automatic logic is_mul_op(ALU_control_t op);
        return op inside {ALU_mul, ALU_mulh, ALU_mulhsu, ALU_mulhu};
    endfunction

    function automatic logic is_div_op(ALU_control_t op);
        return op inside {ALU_div, ALU_divu, ALU_rem, ALU_remu};
    endfunction

    function automatic logic is_known_op(ALU_control_t op);
        return op inside {[ALU_add:ALU_remu]};
    endfunction

    // Operand a / b treated as two's complement by the iterative datapath
    function automatic logic signed_a(ALU_control_t op);
        return op inside {ALU_mul, ALU_mulh, ALU_mulhsu, ALU_div, ALU_rem};
    endfunction

    function automatic logic signed_b(ALU_control_t op);
        return op inside {ALU_mul, ALU_mulh, ALU_div, ALU_rem};
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Issue/result handshake bundle between operand select, the execute unit and writeback.
interface alu_seq_if #(parameter int XLEN = 32);
    import alu_seq_pkg::*;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    ALU_control_t    op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (output flush, in_valid, op, a, b, out_ready,
                    input  in_ready, out_valid, result, busy);
    modport slave  (input  flush, in_valid, op, a, b, out_ready,
                    output in_ready, out_valid, result, busy);
endinterface

// File: rtl/alu_seq_muldiv_iter.sv
// Iterative RV-M datapath: shift-add multiply and restoring divide on operand magnitudes.
module alu_seq_muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int MUL_UNROLL = MUL_UNROLL_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  ALU_control_t    op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] res
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_UNROLL - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

    ALU_control_t      op_q;
    logic              active, neg_a, neg_x, s_a, s_b;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   hi, lo, dv, h_n, l_n, mag_a, mag_b;
    logic [XLEN:0]     acc, r, diff;
    logic [2*XLEN-1:0] prod;

    assign s_a   = signed_a(op) & a[XLEN-1];
    assign s_b   = signed_b(op) & b[XLEN-1];
    assign mag_a = s_a ? -a : a;
    assign mag_b = s_b ? -b : b;
    assign done  = active && (cnt == '0);

    // mul: hi accumulates, lo holds multiplier then low product; div: hi remainder, lo quotient
    always_comb begin
        h_n  = hi;
        l_n  = lo;
        acc  = '0;
        r    = '0;
        diff = '0;
        if (is_mul_op(op_q)) begin
            for (int k = 0; k < MUL_UNROLL; k++) begin
                acc = {1'b0, h_n} + (l_n[0] ? {1'b0, dv} : '0);
                l_n = {acc[0], l_n[XLEN-1:1]};
                h_n = acc[XLEN:1];
            end
        end else begin
            r    = {h_n, l_n[XLEN-1]};
            diff = r - {1'b0, dv};
            if (!diff[XLEN]) begin
                h_n = diff[XLEN-1:0];
                l_n = {l_n[XLEN-2:0], 1'b1};
            end else begin
                h_n = r[XLEN-1:0];
                l_n = {l_n[XLEN-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod = {h_n, l_n};
        if (neg_x) prod = -prod;
        case (op_q)
            ALU_mul:                        res = prod[XLEN-1:0];
            ALU_mulh, ALU_mulhsu, ALU_mulhu: res = prod[2*XLEN-1:XLEN];
            ALU_div, ALU_divu:              res = neg_x ? -l_n : l_n;
            default:                        res = neg_a ? -h_n : h_n;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            dv     <= '0;
            neg_a  <= 1'b0;
            neg_x  <= 1'b0;
            op_q   <= ALU_add;
        end else if (flush) begin
            active <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            op_q   <= op;
            neg_a  <= s_a;
            neg_x  <= s_a ^ s_b;
            hi     <= '0;
            lo     <= is_mul_op(op) ? mag_b : mag_a;
            dv     <= is_mul_op(op) ? mag_a : mag_b;
            cnt    <= is_mul_op(op) ? MUL_LAST : DIV_LAST;
        end else if (active) begin
            hi  <= h_n;
            lo  <= l_n;
            cnt <= cnt - 1'b1;
            if (cnt == '0) active <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Handshaked EX unit: single-cycle ALU ops plus iterative mul/div, registered result.
// state | meaning
// IDLE  | no op in flight, ready to accept
// MUL   | multiply iterating in alu_seq_muldiv_iter
// DIV   | divide iterating in alu_seq_muldiv_iter
// DONE  | result held on bus until out_ready
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int MUL_UNROLL = MUL_UNROLL_DEFAULT
) (
    input logic     clk,
    input logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    alu_seq_state_t         state, state_n;
    logic [XLEN-1:0]        result_q, result_n, basic_res, md_res;
    logic                   accept, md_start, md_done, div_zero, div_ovf, short_div;
    logic [SW-1:0]          shamt;
    logic signed [XLEN-1:0] sa, sb;

    assign sa        = bus.a;
    assign sb        = bus.b;
    assign shamt     = bus.b[SW-1:0];
    assign div_zero  = (bus.b == '0);
    assign div_ovf   = (bus.op inside {ALU_div, ALU_rem}) && (bus.a == SMIN) && (bus.b == '1);
    assign short_div = is_div_op(bus.op) && (div_zero || div_ovf);

    assign bus.in_ready  = !bus.flush && ((state == IDLE) || ((state == DONE) && bus.out_ready));
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == MUL) || (state == DIV);
    assign bus.result    = result_q;

    // Division corner cases resolve here without iterating
    always_comb begin
        basic_res = '0;
        case (bus.op)
            ALU_add:           basic_res = bus.a + bus.b;
            ALU_sub:           basic_res = bus.a - bus.b;
            ALU_and:           basic_res = bus.a & bus.b;
            ALU_or:            basic_res = bus.a | bus.b;
            ALU_xor:           basic_res = bus.a ^ bus.b;
            ALU_sll:           basic_res = bus.a << shamt;
            ALU_srl:           basic_res = bus.a >> shamt;
            ALU_sra:           basic_res = sa >>> shamt;
            ALU_slt:           basic_res = {{(XLEN-1){1'b0}}, sa < sb};
            ALU_sltu:          basic_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
            ALU_ce:            basic_res = {{(XLEN-1){1'b0}}, bus.a == bus.b};
            ALU_cne:           basic_res = {{(XLEN-1){1'b0}}, bus.a != bus.b};
            ALU_cge:           basic_res = {{(XLEN-1){1'b0}}, sa >= sb};
            ALU_cgeu:          basic_res = {{(XLEN-1){1'b0}}, bus.a >= bus.b};
            ALU_div, ALU_divu: basic_res = div_zero ? '1 : SMIN;
            ALU_rem, ALU_remu: basic_res = div_zero ? bus.a : '0;
            default:           basic_res = '0;
        endcase
    end

    always_comb begin
        state_n  = state;
        result_n = result_q;
        md_start = 1'b0;
        case (state)
            MUL, DIV: begin
                if (md_done) begin
                    state_n  = DONE;
                    result_n = md_res;
                end
            end
            default: begin
                if (state == IDLE || bus.out_ready) state_n = IDLE;
                if (accept) begin
                    if (is_mul_op(bus.op)) begin
                        state_n  = MUL;
                        md_start = 1'b1;
                    end else if (is_div_op(bus.op) && !short_div) begin
                        state_n  = DIV;
                        md_start = 1'b1;
                    end else begin
                        state_n  = DONE;
                        result_n = basic_res;
                    end
                end
            end
        endcase
        if (bus.flush) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            result_q <= '0;
        end else begin
            state    <= state_n;
            result_q <= result_n;
        end
    end

    alu_seq_muldiv_iter #(.XLEN(XLEN), .MUL_UNROLL(MUL_UNROLL)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.flush),
        .start (md_start),
        .op    (bus.op),
        .a     (bus.a),
        .b     (bus.b),
        .done  (md_done),
        .res   (md_res)
    );

    a_known_op: assert property (@(posedge clk) disable iff (!rst_n) accept |-> is_known_op(bus.op));
endmodule
